// File: rtl/grid_ram_pkg.sv
// Shared definitions for banked_grid_ram: controller states and the read-response record.
`ifndef GRID_VEC_ALIGN_N
`define GRID_VEC_ALIGN_N 32
`endif

package grid_ram_pkg;
  localparam int GRID_DATA_W = `GRID_VEC_ALIGN_N;
  localparam int GRID_BANK_W = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  typedef struct packed {
    logic [GRID_BANK_W-1:0] bank;
    logic [GRID_DATA_W-1:0] data;
  } rsp_t;
endpackage

// File: rtl/grid_ram_bank.sv
// Single-port RAM bank: enable-gated access, registered read, per-bit masked write.
module grid_ram_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_wmask,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Read data refreshes only on reads, so it holds through later writes and clears.
  always_ff @(posedge i_clock) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= (r_mem[i_addr] & ~i_wmask) | (i_wdata & i_wmask);
    end
    if (i_en && !i_we) begin
      o_rdata <= r_mem[i_addr];
    end
  end
endmodule

// File: rtl/banked_grid_ram.sv
// Multi-bank grid row RAM with valid/ready requests, masked writes, fixed-latency reads
// and a clear engine that zeroes every bank after reset or on command.
module banked_grid_ram
  import grid_ram_pkg::*;
#(
  parameter int DATA_WIDTH = GRID_DATA_W,
  parameter int DEPTH      = 16,
  parameter int N_BANKS    = 4,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int BANK_WIDTH = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  parameter int OUT_REG    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [BANK_WIDTH-1:0] req_bank,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  rsp_valid,
  output logic [BANK_WIDTH-1:0] rsp_bank,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output state_t                dbg_state
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready never depends on req_valid, and clear_start takes priority over requests.
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t              r_state, w_state_nxt;
  logic [MEM_AW-1:0]   r_ptr, w_ptr_nxt;
  logic                w_clearing, w_acc, w_acc_rd, w_acc_wr, w_in_range;
  logic [MEM_AW-1:0]   w_bank_addr;
  logic [DATA_WIDTH-1:0] w_bank_wdata, w_bank_wmask;
  logic [DATA_WIDTH-1:0] w_rdata [N_BANKS];
  logic [DATA_WIDTH-1:0] w_rd_mux;

  assign w_clearing = (r_state == ST_CLEAR);
  assign clear_busy = w_clearing;
  assign req_ready  = (r_state == ST_IDLE) && !clear_start;
  assign dbg_state  = r_state;

  assign w_acc      = req_valid && req_ready;
  assign w_in_range = (32'(req_addr) < 32'(DEPTH)) && (32'(req_bank) < 32'(N_BANKS));
  assign w_acc_rd   = w_acc && !req_write;
  assign w_acc_wr   = w_acc && req_write && w_in_range;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_CLEAR: begin
        if (r_ptr == MEM_AW'(DEPTH - 1)) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + MEM_AW'(1);
        end
      end
      ST_IDLE: begin
        if (clear_start) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // While clearing, every bank sees an all-ones-mask write of zero at the clear pointer.
  assign w_bank_addr  = w_clearing ? r_ptr : req_addr[MEM_AW-1:0];
  assign w_bank_wdata = w_clearing ? '0 : req_wdata;
  assign w_bank_wmask = w_clearing ? '1 : req_wmask;

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic w_sel;
    assign w_sel = w_in_range && (req_bank == BANK_WIDTH'(b));

    grid_ram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (MEM_AW)
    ) u_bank (
      .i_clock (clock),
      .i_en    (w_clearing || ((w_acc_rd || w_acc_wr) && w_sel)),
      .i_we    (w_clearing || req_write),
      .i_addr  (w_bank_addr),
      .i_wdata (w_bank_wdata),
      .i_wmask (w_bank_wmask),
      .o_rdata (w_rdata[b])
    );
  end

  logic                  r_vld_s0, r_oor_s0;
  logic [BANK_WIDTH-1:0] r_bank_s0;

  // r_oor_s0 resets high so the unregistered output path reads as zero before any read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_s0  <= 1'b0;
      r_oor_s0  <= 1'b1;
      r_bank_s0 <= '0;
    end else begin
      r_vld_s0 <= w_acc_rd;
      if (w_acc_rd) begin
        r_bank_s0 <= req_bank;
        r_oor_s0  <= !w_in_range;
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (!r_oor_s0 && (r_bank_s0 == BANK_WIDTH'(b))) begin
        w_rd_mux = w_rdata[b];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  r_vld_s1;
    logic [BANK_WIDTH-1:0] r_bank_s1;
    logic [DATA_WIDTH-1:0] r_data_s1;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_vld_s1  <= 1'b0;
        r_bank_s1 <= '0;
        r_data_s1 <= '0;
      end else begin
        r_vld_s1 <= r_vld_s0;
        if (r_vld_s0) begin
          r_bank_s1 <= r_bank_s0;
          r_data_s1 <= w_rd_mux;
        end
      end
    end

    assign rsp_valid = r_vld_s1;
    assign rsp_bank  = r_bank_s1;
    assign rsp_data  = r_data_s1;
  end else begin : g_no_out_reg
    assign rsp_valid = r_vld_s0;
    assign rsp_bank  = r_bank_s0;
    assign rsp_data  = w_rd_mux;
  end
endmodule

// File: doc/banked_grid_ram.md
# banked_grid_ram

Parametrised multi-bank synchronous RAM for grid row storage, replacing per-bank single-port instances with one block that owns all banks. Adds:
- a valid/ready request interface;
- bit-masked writes;
- a configurable read pipeline with a response valid;
- a hardware clear engine that zeroes every bank after reset or on command.

Sits between the grid loader/scanner and storage; one request per cycle, fixed read latency.

## Interface
Parameters:
- DATA_WIDTH, default `GRID_VEC_ALIGN_N, word width per bank
- DEPTH, default 16, words per bank (need not be a power of two)
- N_BANKS, default 4, number of banks (≥1)
- ADDR_WIDTH, default $clog2(DEPTH), word address width
- BANK_WIDTH, default max(1,$clog2(N_BANKS)), bank select width
- OUT_REG, default 1, 0 or 1; adds an output register stage to reads

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_bank  in  BANK_WIDTH  target bank
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_wmask  in  DATA_WIDTH  per-bit write enable
- clear_start  in  1  request full clear of all banks
- clear_busy  out  1  clear engine active
- rsp_valid  out  1  read data valid, one-cycle pulse per read
- rsp_bank  out  BANK_WIDTH  bank of the returned read
- rsp_data  out  DATA_WIDTH  read data

## Operation
- FSM states: CLEAR, IDLE. Reset forces CLEAR with clear pointer 0.
- CLEAR:
  - each cycle, write 0 to word[ptr] in every bank, then ptr++;
  - on ptr == DEPTH-1, write it and go to IDLE next cycle;
  - lasts exactly DEPTH cycles;
  - clear_start ignored.
- IDLE: clear_start=1 → CLEAR at next edge with ptr=0.
- req_ready = (state==IDLE) && !clear_start. Clear wins over a simultaneous request.
- Accepted write: for each bit i, mem[bank][addr][i] ← wdata[i] where wmask[i]=1; other bits unchanged. Other banks untouched. No response.
- Accepted read: returns mem[bank][addr]. A read immediately after a write to the same location returns the new data.
- Out-of-range (addr ≥ DEPTH or bank ≥ N_BANKS): write dropped; read still produces rsp_valid with rsp_data = 0.
- Reads in flight when CLEAR begins complete normally with pre-clear data.
- Memory array itself is not reset; contents are defined only via the clear engine.
- rsp_data/rsp_bank hold the last read result while rsp_valid is low.

## Timing
- Read accepted at edge k → rsp_valid high for the cycle after edge k+OUT_REG:
  - latency 1 cycle with OUT_REG=0;
  - latency 2 cycles with OUT_REG=1.
- Back-to-back reads give back-to-back rsp_valid, in order, one per cycle.
- Write takes effect at the accepting edge; a read accepted on the next edge sees it.
- After reset deassertion: clear_busy=1 and req_ready=0 for DEPTH cycles, then clear_busy=0 and req_ready=1.
- Reset values: req_ready 0, clear_busy 1, rsp_valid 0, rsp_bank 0, rsp_data 0, pipeline valids 0, ptr 0.
- Reset asserted mid-clear or mid-read:
  - in-flight responses are discarded (rsp_valid 0);
  - clear restarts from ptr 0.
- clear_start assertion to clear_busy high: one edge.

## Structure
- Package grid_ram_pkg: state enum (CLEAR, IDLE) and a response struct {bank, data} parameterised via a localparam width derived from `GRID_VEC_ALIGN_N.
- Sub-module grid_ram_bank, instantiated N_BANKS times:
  - one port, registered read, bit-masked write, enable input;
  - top-level muxes clear writes (mask all-ones, data 0) onto every bank.
- Top level holds the FSM, request decode, valid/bank pipeline (1+OUT_REG stages), and the output mux.

## Test plan
- Reset then idle: clear_busy high exactly 16 cycles (DEPTH=16), req_ready low throughout; then read bank 2 addr 5 → rsp_data 0.
- Write bank 1 addr 3 data 0xFF.., mask all-ones; read next cycle → rsp_valid exactly 2 cycles after acceptance (OUT_REG=1), data all-ones, rsp_bank 1; other banks at addr 3 read 0.
- Masked write: write all-ones, then write 0 with mask = low half set → read returns upper half ones, lower half zero.
- Streamed reads of addrs 0..7 on bank 0 with distinct contents: eight consecutive rsp_valid cycles, data in order.
- clear_start with simultaneous req_valid write: write not accepted (req_ready 0); after DEPTH cycles all locations read 0; a read issued one cycle before clear_start returns old data.
- reset_n pulsed low at clear ptr 8 and during an outstanding read: rsp_valid stays 0, clear restarts and again takes 16 cycles.
